// File: rtl/sseg_pkg.sv
// Shared definitions for the four-digit seven-segment interface.
// Holds the display constants, the scan state encoding and the hex-to-segment
// patterns used by both the heartbeat producer and the scan driver.
// Segment patterns are active-low: bit 7 = DP, bits 6:0 = g..a.
package sseg_pkg;

  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Patterns for hex digits 0-F, decimal point off.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
    return HEX_SEG[value];
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot timer for the scan driver.
// Counts clocks within a digit slot and steps the digit index on each slot
// wrap. A synchronous clear (or reset) returns both to zero.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   clear        - hold counter and index at zero
//   slot_cnt     - position within the current slot
//   idx          - digit currently being scanned (0..3)
//   slot_start   - slot_cnt is zero
//   frame_end    - last clock of digit 3's slot
module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter int SLOT_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  output logic [SLOT_WIDTH-1:0] slot_cnt,
  output logic [1:0]            idx,
  output logic                  slot_start,
  output logic                  frame_end
);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt == '1) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    slot_start = (slot_cnt == '0);
    frame_end  = (idx == 2'd3) && (slot_cnt == '1);
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed driver for a common-anode four-digit display.
// Captures each digit's pattern at the start of its slot, blanks all anodes
// for BLANK_CYCLES at the start of each slot, applies 16-level brightness
// and pulses frame_tick once per complete four-digit scan.
// Ports:
//   clk, resetn     - clock, synchronous active-low reset
//   enable          - scan enable; low darkens the display and restarts the scan
//   brightness      - lit fraction of each slot in sixteenths (0 = dark)
//   dig_0..dig_3    - active-low segment patterns, digit 0 rightmost
//   an, seg         - active-low anode and segment drive (registered)
//   frame_tick      - one-cycle pulse after each complete scan
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int SLOT_WIDTH   = 17,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [3:0] brightness,
  input  logic [7:0] dig_0,
  input  logic [7:0] dig_1,
  input  logic [7:0] dig_2,
  input  logic [7:0] dig_3,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam logic [SLOT_WIDTH-1:0] BLANK_END = SLOT_WIDTH'(BLANK_CYCLES);

  scan_state_t           state;
  logic [SLOT_WIDTH-1:0] slot_cnt;
  logic [1:0]            idx;
  logic                  slot_start;
  logic                  frame_end;
  logic                  run;
  logic                  lit;
  logic [4:0]            level;
  logic [7:0]            digs   [NUM_DIGITS];
  logic [7:0]            shadow [NUM_DIGITS];

  // Gating with enable as well as state makes an enable drop darken the very
  // next output cycle and suppresses a frame_tick on that same edge.
  assign run = (state == SCAN) && enable;

  sseg_slot_timer #(
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (!run),
    .slot_cnt   (slot_cnt),
    .idx        (idx),
    .slot_start (slot_start),
    .frame_end  (frame_end)
  );

  always_comb begin
    digs[0] = dig_0;
    digs[1] = dig_1;
    digs[2] = dig_2;
    digs[3] = dig_3;
    level   = {1'b0, slot_cnt[SLOT_WIDTH-1 -: 4]};
    lit     = run && (slot_cnt >= BLANK_END) && (level < {1'b0, brightness});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      an         <= AN_ALL_OFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_BLANK;
    end else begin
      case (state)
        IDLE:    if (enable)  state <= SCAN;
        SCAN:    if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase

      if ((state == SCAN) && slot_start) shadow[idx] <= digs[idx];

      if (lit) begin
        an  <= ~(4'b0001 << idx);
        seg <= shadow[idx];
      end else begin
        an  <= AN_ALL_OFF;
        seg <= SEG_BLANK;
      end

      frame_tick <= run && frame_end;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

  localparam int SW    = 6;
  localparam int BLANK = 4;
  localparam int SLOT  = 1 << SW;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [7:0] dig [4];
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: time since scan start plus captured patterns.
  bit         m_scan = 0;
  int         m_k = 0;
  logic [7:0] m_sh [4];
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_ft;

  sseg_scan_driver #(
    .SLOT_WIDTH   (SW),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .brightness (brightness),
    .dig_0      (dig[0]),
    .dig_1      (dig[1]),
    .dig_2      (dig[2]),
    .dig_3      (dig[3]),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model step for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    int  slot, pos;
    bit  live, lit;
    if (!resetn) begin
      exp_an = 4'hF; exp_seg = 8'hFF; exp_ft = 1'b0;
      m_scan = 0; m_k = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
    end else begin
      slot = (m_k / SLOT) % 4;
      pos  = m_k % SLOT;
      live = m_scan && enable;
      lit  = live && (pos >= BLANK) && ((pos * 16 / SLOT) < int'(brightness));
      exp_an  = lit ? ~(4'(1) << slot) : 4'hF;
      exp_seg = lit ? m_sh[slot] : 8'hFF;
      exp_ft  = live && (slot == 3) && (pos == SLOT - 1);
      if (m_scan && pos == 0) m_sh[slot] = dig[slot];
      if (live) m_k++; else m_k = 0;
      m_scan = enable;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_an", 32'(an), 32'(exp_an));
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  // Advance until the next edge will evaluate the given slot/position.
  task automatic wait_pos(input int s, input int p);
    bit found = 0;
    for (int i = 0; i < 700; i++) begin
      if (m_scan && enable && ((m_k / SLOT) % 4 == s) && (m_k % SLOT == p)) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_pos timeout: slot %0d pos %0d not reached", s, p);
    end
  endtask

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [7:0] seg;
    logic       ft;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int done;
    int lit_cnt;
    int ft_cnt;

    vecs[0]  = '{1,   4'hF, 8'hFF, 1'b0};
    vecs[1]  = '{4,   4'hF, 8'hFF, 1'b0};
    vecs[2]  = '{5,   4'hE, 8'hC0, 1'b0};
    vecs[3]  = '{60,  4'hE, 8'hC0, 1'b0};
    vecs[4]  = '{61,  4'hF, 8'hFF, 1'b0};
    vecs[5]  = '{64,  4'hF, 8'hFF, 1'b0};
    vecs[6]  = '{69,  4'hD, 8'hF9, 1'b0};
    vecs[7]  = '{133, 4'hB, 8'hA4, 1'b0};
    vecs[8]  = '{197, 4'h7, 8'hB0, 1'b0};
    vecs[9]  = '{256, 4'hF, 8'hFF, 1'b1};
    vecs[10] = '{257, 4'hF, 8'hFF, 1'b0};
    vecs[11] = '{261, 4'hE, 8'hC0, 1'b0};
    vecs[12] = '{512, 4'hF, 8'hFF, 1'b1};

    dig[0] = 8'hC0; dig[1] = 8'hF9; dig[2] = 8'hA4; dig[3] = 8'hB0;
    for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;

    // Reset held with enable high.
    resetn = 1'b0; enable = 1'b1; brightness = 4'd15;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_an", 32'(an), 32'h F);
      check("reset_seg", 32'(seg), 32'h FF);
      check("reset_ft", 32'(frame_tick), 32'h0);
    end

    // Release: this edge moves IDLE -> SCAN, outputs still dark.
    resetn = 1'b1;
    tick();
    check("release_an", 32'(an), 32'h F);
    check("release_seg", 32'(seg), 32'h FF);

    // Full scan, table of edges counted after the release edge.
    done = 0;
    foreach (vecs[v]) begin
      while (done < vecs[v].n) begin
        tick();
        done++;
      end
      check($sformatf("tbl%0d_an", v), 32'(an), 32'(vecs[v].an));
      check($sformatf("tbl%0d_seg", v), 32'(seg), 32'(vecs[v].seg));
      check($sformatf("tbl%0d_ft", v), 32'(frame_tick), 32'(vecs[v].ft));
    end

    // Capture stability on digit 1.
    wait_pos(1, 20);
    dig[1] = 8'h80;
    wait_pos(1, 40);
    tick();
    check("capture_old_an", 32'(an), 32'h D);
    check("capture_old_seg", 32'(seg), 32'h F9);
    wait_pos(1, 40);
    tick();
    check("capture_new_seg", 32'(seg), 32'h 80);

    // Brightness 7: positions 4..27 lit.
    brightness = 4'd7;
    wait_pos(2, 0);
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin
      tick();
      if (an != 4'hF) lit_cnt++;
    end
    check("bright7_lit_count", 32'(lit_cnt), 32'd24);

    // Brightness 0: dark, frame_tick still pulses.
    brightness = 4'd0;
    wait_pos(0, 0);
    lit_cnt = 0; ft_cnt = 0;
    for (int i = 0; i < 4 * SLOT; i++) begin
      tick();
      if (an != 4'hF) lit_cnt++;
      if (frame_tick) ft_cnt++;
    end
    check("bright0_lit_count", 32'(lit_cnt), 32'd0);
    check("bright0_ft_count", 32'(ft_cnt), 32'd1);
    brightness = 4'd15;

    // Enable drop mid-slot, then restart at digit 0.
    wait_pos(2, 10);
    enable = 1'b0;
    tick();
    check("drop_an", 32'(an), 32'h F);
    check("drop_seg", 32'(seg), 32'h FF);
    check("drop_ft", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("restart_blank_an", 32'(an), 32'h F);
    end
    tick();
    check("restart_an", 32'(an), 32'h E);
    check("restart_seg", 32'(seg), 32'h C0);

    // Reset mid-scan.
    wait_pos(3, 30);
    resetn = 1'b0;
    tick();
    check("midreset_an", 32'(an), 32'h F);
    check("midreset_seg", 32'(seg), 32'h FF);
    check("midreset_ft", 32'(frame_tick), 32'h0);
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("after_reset_an", 32'(an), 32'h E);
    check("after_reset_seg", 32'(seg), 32'h C0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) brightness = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) dig[$urandom_range(3)] = 8'($urandom);
      enable = ($urandom_range(299) != 0);
      resetn = ($urandom_range(999) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
